// File: rtl/counter_pkg.sv
// counter_pkg: state encoding and default timings shared by countup_pulse_gen.
package counter_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY = 50;
    localparam int DEF_REPEAT_PERIOD = 20;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous level into clk.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk or posedge rst)
        if (rst) r <= '0;
        else     r <= {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/countup_pulse_gen.sv
// countup_pulse_gen: synchronise + debounce a button, one countup pulse per press.
// Define COUNTUP_PULSE_GEN_REPEAT_EN to add auto-repeat pulses while held.
module countup_pulse_gen
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    output logic             countup,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_count
);
    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] DB  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE = CW'(1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic s, fire, level_n, rpt_fire;
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(s));
`ifdef COUNTUP_PULSE_GEN_REPEAT_EN
    localparam logic [CW-1:0] RD = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP = CW'(REPEAT_PERIOD);
    logic [CW-1:0] rpt, rpt_n;
    logic first, first_n;
    // rpt only advances on cycles that stay in HELD, so RELEASE_WAIT freezes it
    always_comb begin
        rpt_fire = (state == HELD) && s && (rpt + ONE == (first ? RD : RP));
        rpt_n    = (state == PRESS_WAIT) ? '0 : ((state == HELD) && s) ? (rpt_fire ? '0 : rpt + ONE) : rpt;
        first_n  = (state == PRESS_WAIT) ? 1'b1 : rpt_fire ? 1'b0 : first;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rpt   <= '0;
            first <= 1'b1;
        end else begin
            rpt   <= rpt_n;
            first <= first_n;
        end
`else
    assign rpt_fire = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            countup     <= 1'b0;
            btn_level   <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            countup     <= fire;
            btn_level   <= level_n;
            press_count <= press_count + CNT_W'(fire);
        end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (s) begin
                state_n = PRESS_WAIT;
                cnt_n   = ONE;
            end
            PRESS_WAIT: if (!s) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (cnt == DB) state_n = HELD;
            else cnt_n = cnt + ONE;
            HELD: if (!s) begin
                state_n = RELEASE_WAIT;
                cnt_n   = ONE;
            end
            RELEASE_WAIT: if (s) state_n = HELD;
            else if (cnt == DB) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else cnt_n = cnt + ONE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        fire    = ((state == PRESS_WAIT) && s && (cnt == DB)) || rpt_fire;
        level_n = (state_n == HELD) || (state_n == RELEASE_WAIT);
    end
endmodule

// File: tb/tb_countup_pulse_gen.sv
// tb_countup_pulse_gen: random bouncy presses checked against a run-length model.
module tb_countup_pulse_gen;
    localparam int SYNC = 2, DB = 4, CW = 8;
`ifdef COUNTUP_PULSE_GEN_REPEAT_EN
    localparam int RD = 10, RP = 5;
    localparam bit REP = 1'b1;
`else
    localparam int RD = 50, RP = 20;
    localparam bit REP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, btn_in = 1'b0;
    logic countup, btn_level;
    logic [CW-1:0] press_count;
    int vectors = 0, miscompares = 0;

    countup_pulse_gen #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .countup(countup), .btn_level(btn_level), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the debounced level flips once DB+1 consecutive synchronised samples disagree with it.
    bit q[$];
    int run1 = 0, run0 = 0, held_cycles = 0, m_count = 0;
    bit lvl = 0, prev_s = 0, m_pulse = 0, prev_cu = 0;
    always @(posedge clk) begin
        bit s, held_before;
        if (rst) begin
            q = {};
            repeat (SYNC) q.push_back(1'b0);
            run1 = 0; run0 = 0; held_cycles = 0; m_count = 0;
            lvl = 0; prev_s = 0; m_pulse = 0;
        end else begin
            s = q.pop_front();
            q.push_back(btn_in);
            held_before = lvl && prev_s;
            run1 = s ? run1 + 1 : 0;
            run0 = s ? 0 : run0 + 1;
            m_pulse = 0;
            if (!lvl && run1 == DB + 1) begin
                lvl = 1; m_pulse = 1; held_cycles = 0;
            end else if (lvl && run0 == DB + 1) begin
                lvl = 0;
            end else if (REP && held_before && s) begin
                held_cycles++;
                if (held_cycles == RD || (held_cycles > RD && (held_cycles - RD) % RP == 0))
                    m_pulse = 1;
            end
            if (m_pulse) m_count = (m_count + 1) % (1 << CW);
            prev_s = s;
        end
        #1;
        check("countup", countup, m_pulse);
        check("btn_level", btn_level, lvl);
        check("press_count", press_count, m_count);
        if (countup && RP > 1) check("adjacent_pulse", prev_cu, 0);
        prev_cu = countup;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hi, input int lo);
        btn_in = 1'b1; cyc(hi);
        btn_in = 1'b0; cyc(lo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn_in = 1'b0;
        cyc(3);
        rst = 1'b0;
    endtask

    initial begin
        int lat, c1, c2;
        c1 = REP ? 3 : 1;
        c2 = c1 + (REP ? 3 : 1);
        cyc(3);
        rst = 1'b0;
        check("reset_count", press_count, 0);
        check("reset_level", btn_level, 0);
        // 1: clean long press, latency and width pinned by hand
        btn_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (countup) begin lat = k; break; end
        end
        check("latency", lat, 7);
        @(posedge clk); #1;
        check("pulse_width", countup, 0);
        check("level_on", btn_level, 1);
        check("first_count", press_count, 1);
        @(negedge clk); cyc(12);
        btn_in = 1'b0; cyc(10);
        check("hold_count", press_count, c1);
        check("level_off", btn_level, 0);
        // 2: short press rejected
        press(3, 15);
        check("short_count", press_count, c1);
        check("short_level", btn_level, 0);
        // 3: release glitch
        btn_in = 1'b1; cyc(20);
        btn_in = 1'b0; cyc(1);
        btn_in = 1'b1; cyc(1);
        btn_in = 1'b0; cyc(15);
        check("glitch_count", press_count, c2);
        // 4: twelve clean presses
        repeat (12) press(10, 10);
        check("twelve_count", press_count, c2 + 12);
        // 5: async reset while held
        do_reset();
        repeat (4) press(10, 10);
        btn_in = 1'b1; cyc(9);
        check("held_count", press_count, 5);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_count", press_count, 0);
        check("async_level", btn_level, 0);
        btn_in = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        check("post_reset_count", press_count, 0);
        press(10, 10);
        check("next_press_count", press_count, 1);
        // wrap modulo 2^CW
        do_reset();
        repeat (260) press(6, 6);
        check("wrap_count", press_count, 4);
        // random bouncy presses
        for (int p = 0; p < 300; p++) begin
            for (int b = $urandom_range(0, 3); b > 0; b--) begin
                btn_in = 1'b1; cyc($urandom_range(1, 3));
                btn_in = 1'b0; cyc($urandom_range(1, 3));
            end
            btn_in = 1'b1; cyc($urandom_range(1, REP ? 40 : 15));
            if ($urandom_range(0, 3) == 0) begin
                btn_in = 1'b0; cyc($urandom_range(1, 2));
                btn_in = 1'b1; cyc($urandom_range(1, 10));
            end
            btn_in = 1'b0; cyc($urandom_range(1, 12));
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
